// File: rtl/spi_mmio_core_if.sv
// ---------------------------------------------------------------------------
// spi_mmio_core_if
// MMIO slot bus between the subsystem's slot decoder and a slot core.
//   cs       : slot chip select
//   read     : read strobe (qualified by cs)
//   write    : write strobe (qualified by cs)
//   addr     : slot register index (5 bits)
//   wr_data  : write data (32 bits)
//   rd_data  : read data returned by the slot (32 bits)
// master modport = bus driver (decoder / testbench), slave modport = core.
// ---------------------------------------------------------------------------
interface spi_mmio_core_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output cs,
        output read,
        output write,
        output addr,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  cs,
        input  read,
        input  write,
        input  addr,
        input  wr_data,
        output rd_data
    );
endinterface

// File: rtl/spi_mmio_core.sv
// ---------------------------------------------------------------------------
// spi_mmio_core
// Single-slot SPI master on the MMIO slot bus. Full-duplex, 8 bits per
// transfer, MSB first, programmable half-period (dvsr+1 clocks), cpol/cpha.
//
// Ports:
//   clk       : system clock
//   reset     : asynchronous, active-high reset
//   bus       : MMIO slot bus (slave modport)
//                 addr 1 write -> slave selects
//                 addr 2 write -> start transfer with wr_data[7:0] (idle only)
//                 addr 3 write -> {cpha, cpol, dvsr} = wr_data[17:0] (idle only)
//                 rd_data      -> {23'b0, ready, rx[7:0]} for any address
//   spi_sclk  : SPI clock (registered)
//   spi_mosi  : SPI data out (registered)
//   spi_miso  : SPI data in
//   spi_ss_n  : active-low slave selects, owned entirely by software
// ---------------------------------------------------------------------------
module spi_mmio_core #(
    parameter int S = 1
) (
    input  logic           clk,
    input  logic           reset,
    spi_mmio_core_if.slave bus,
    output logic           spi_sclk,
    output logic           spi_mosi,
    input  logic           spi_miso,
    output logic [S-1:0]   spi_ss_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DLY  = 2'd1,
        P0   = 2'd2,
        P1   = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_next;

    logic [15:0]  r_cnt;
    logic [15:0]  w_cnt_next;
    logic [15:0]  r_dvsr;
    logic         r_cpol;
    logic         r_cpha;

    // Separate outgoing and incoming shift registers, so capturing miso never
    // clobbers a tx bit that has not been driven yet.
    logic [7:0]   r_so;
    logic [7:0]   w_so_next;
    logic [7:0]   r_si;
    logic [7:0]   w_si_next;
    logic [7:0]   r_rx;
    logic [7:0]   w_rx_next;
    logic [2:0]   r_bit;
    logic [2:0]   w_bit_next;

    logic         r_mosi;
    logic         w_mosi_next;
    logic         r_sclk;
    logic         w_sclk_next;
    logic [S-1:0] r_ss_n;

    logic         w_wr;
    logic         w_ss_wr;
    logic         w_start;
    logic         w_ctrl_wr;
    logic         w_last;
    logic         w_ready;
    logic         w_unused;

    // Bus decode; only addr[1:0] is significant.
    assign w_wr      = bus.cs & bus.write;
    assign w_ready   = (r_state == IDLE);
    assign w_ss_wr   = w_wr && (bus.addr[1:0] == 2'd1);
    assign w_start   = w_wr && (bus.addr[1:0] == 2'd2) && w_ready;
    assign w_ctrl_wr = w_wr && (bus.addr[1:0] == 2'd3) && w_ready;
    assign w_last    = (r_cnt == r_dvsr);

    assign bus.rd_data = {23'b0, w_ready, r_rx};

    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_ss_n = r_ss_n;

    // Bus bits the core never looks at.
    assign w_unused = ^{bus.read, bus.addr[4:2], bus.wr_data[31:18]};

    // State register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_so    <= '0;
            r_si    <= '0;
            r_rx    <= '0;
            r_bit   <= '0;
            r_mosi  <= 1'b0;
            r_sclk  <= 1'b0;
            r_ss_n  <= '1;
            r_dvsr  <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_so    <= w_so_next;
            r_si    <= w_si_next;
            r_rx    <= w_rx_next;
            r_bit   <= w_bit_next;
            r_mosi  <= w_mosi_next;
            r_sclk  <= w_sclk_next;
            if (w_ss_wr) begin
                r_ss_n <= bus.wr_data[S-1:0];
            end
            if (w_ctrl_wr) begin
                r_dvsr <= bus.wr_data[15:0];
                r_cpol <= bus.wr_data[16];
                r_cpha <= bus.wr_data[17];
            end
        end
    end

    // Next-state and datapath logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 16'd1;
        w_so_next    = r_so;
        w_si_next    = r_si;
        w_rx_next    = r_rx;
        w_bit_next   = r_bit;
        w_mosi_next  = r_mosi;

        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_so_next    = bus.wr_data[7:0];
                    w_bit_next   = 3'd0;
                    w_mosi_next  = bus.wr_data[7];
                    w_state_next = r_cpha ? DLY : P0;
                end
            end
            DLY: begin
                if (w_last) begin
                    w_state_next = P0;
                end
            end
            P0: begin
                if (w_last) begin
                    w_si_next    = {r_si[6:0], spi_miso};
                    w_state_next = P1;
                end
            end
            P1: begin
                if (w_last) begin
                    if (r_bit == 3'd7) begin
                        w_rx_next    = r_si;
                        w_state_next = IDLE;
                    end else begin
                        w_so_next    = {r_so[6:0], 1'b0};
                        w_mosi_next  = r_so[6];
                        w_bit_next   = r_bit + 3'd1;
                        w_state_next = P0;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Half-period counter restarts whenever the phase changes, and is
        // parked at zero while idle, so it never runs past dvsr.
        if ((w_state_next != r_state) || (r_state == IDLE)) begin
            w_cnt_next = '0;
        end
    end

    // sclk follows the upcoming phase so it changes on the same edge as the
    // state; this places the miso sample at the end of P0 for either cpha.
    always_comb begin
        case (w_state_next)
            P0:      w_sclk_next = r_cpol ^ r_cpha;
            P1:      w_sclk_next = r_cpol ^ ~r_cpha;
            default: w_sclk_next = r_cpol;
        endcase
    end

endmodule

// File: tb/tb_spi_mmio_core.sv
// ---------------------------------------------------------------------------
// tb_spi_mmio_core
// Directed bench for spi_mmio_core with four slave selects.
// ---------------------------------------------------------------------------
module tb_spi_mmio_core;

    localparam int S = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         spi_sclk;
    logic         spi_mosi;
    logic         spi_miso;
    logic [S-1:0] spi_ss_n;

    logic         miso_loop = 1'b0;
    logic         miso_val  = 1'b0;

    int           n_checks = 0;
    int           n_fail   = 0;

    int           edge_cnt = 0;
    logic [7:0]   mosi_cap = 8'h00;

    spi_mmio_core_if bus ();

    spi_mmio_core #(.S(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_ss_n (spi_ss_n)
    );

    always #5 clk = ~clk;

    assign spi_miso = miso_loop ? spi_mosi : miso_val;

    // Record every sclk rising edge and the mosi bit present at it.
    always @(posedge spi_sclk) begin
        edge_cnt <= edge_cnt + 1;
        mosi_cap <= {mosi_cap[6:0], spi_mosi};
    end

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr    = a;
        bus.wr_data = d;
        bus.cs      = 1'b1;
        bus.write   = 1'b1;
        @(negedge clk);
        bus.cs      = 1'b0;
        bus.write   = 1'b0;
        bus.wr_data = 32'h0;
    endtask

    // Counts negedges with ready low, starting at the negedge right after
    // the start write.
    task automatic wait_ready(output int n);
        n = 0;
        while (bus.rd_data[8] !== 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready timeout: busy %0d cycles, required ready within 2000", n);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.cs      = 1'b0;
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.addr    = 5'd0;
        bus.wr_data = 32'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.rd_data !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL reset_rd_in_reset: got %h want 00000100", bus.rd_data);
        end
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bus.addr = 5'(a);
            @(negedge clk);
            n_checks++;
            if (bus.rd_data !== 32'h0000_0100) begin
                n_fail++;
                $display("FAIL reset_rd_addr%0d: got %h want 00000100", a, bus.rd_data);
            end
        end
        n_checks++;
        if (spi_ss_n !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_ss_n: got %b want 1111", spi_ss_n);
        end
        n_checks++;
        if (spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sclk_mosi: got %b%b want 00", spi_sclk, spi_mosi);
        end
    endtask

    task automatic test_mode0();
        int n;
        int base;
        bus_write(5'd3, 32'h0000_0003);
        bus_write(5'd1, 32'h0000_0000);
        miso_loop = 1'b1;
        base = edge_cnt;
        bus_write(5'd2, 32'h0000_00A5);
        wait_ready(n);
        n_checks++;
        if (n !== 64) begin
            n_fail++;
            $display("FAIL mode0_busy: got %0d want 64", n);
        end
        n_checks++;
        if (edge_cnt - base !== 8) begin
            n_fail++;
            $display("FAIL mode0_edges: got %0d want 8", edge_cnt - base);
        end
        n_checks++;
        if (mosi_cap !== 8'hA5) begin
            n_fail++;
            $display("FAIL mode0_mosi: got %h want a5", mosi_cap);
        end
        n_checks++;
        if (bus.rd_data !== 32'h0000_01A5) begin
            n_fail++;
            $display("FAIL mode0_rx: got %h want 000001a5", bus.rd_data);
        end
    endtask

    task automatic test_mode3();
        int n;
        miso_loop = 1'b0;
        miso_val  = 1'b1;
        bus_write(5'd3, 32'h0003_0000);
        @(negedge clk);
        n_checks++;
        if (spi_sclk !== 1'b1) begin
            n_fail++;
            $display("FAIL mode3_idle_sclk: got %b want 1", spi_sclk);
        end
        bus_write(5'd2, 32'h0000_003C);
        n_checks++;
        if (spi_sclk !== 1'b1) begin
            n_fail++;
            $display("FAIL mode3_dly_sclk: got %b want 1", spi_sclk);
        end
        @(negedge clk);
        n_checks++;
        if (spi_sclk !== 1'b0) begin
            n_fail++;
            $display("FAIL mode3_first_edge: got %b want 0", spi_sclk);
        end
        wait_ready(n);
        n_checks++;
        if (n + 1 !== 17) begin
            n_fail++;
            $display("FAIL mode3_busy: got %0d want 17", n + 1);
        end
        n_checks++;
        if (bus.rd_data !== 32'h0000_01FF) begin
            n_fail++;
            $display("FAIL mode3_rx: got %h want 000001ff", bus.rd_data);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int base;
        bus_write(5'd3, 32'h0000_0003);
        miso_loop = 1'b1;
        repeat (2) @(negedge clk);
        base = edge_cnt;
        bus_write(5'd2, 32'h0000_00A5);
        repeat (5) @(negedge clk);
        bus_write(5'd2, 32'h0000_005A);
        bus_write(5'd3, 32'h0001_0000);
        n_checks++;
        if (bus.rd_data[8] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_still_busy: got ready %b want 0", bus.rd_data[8]);
        end
        wait_ready(n);
        n_checks++;
        if (edge_cnt - base !== 8) begin
            n_fail++;
            $display("FAIL b2b_edges: got %0d want 8", edge_cnt - base);
        end
        n_checks++;
        if (mosi_cap !== 8'hA5) begin
            n_fail++;
            $display("FAIL b2b_mosi: got %h want a5", mosi_cap);
        end
        n_checks++;
        if (bus.rd_data !== 32'h0000_01A5) begin
            n_fail++;
            $display("FAIL b2b_rx: got %h want 000001a5", bus.rd_data);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (spi_sclk !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_cpol_kept: got sclk %b want 0", spi_sclk);
        end
        bus_write(5'd2, 32'h0000_0000);
        wait_ready(n);
        n_checks++;
        if (n !== 64) begin
            n_fail++;
            $display("FAIL b2b_dvsr_kept: got busy %0d want 64", n);
        end
        n_checks++;
        if (bus.rd_data !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL b2b_rx_zero: got %h want 00000100", bus.rd_data);
        end
    endtask

    task automatic test_dvsr0();
        int n;
        int base;
        bus_write(5'd3, 32'h0000_0000);
        miso_loop = 1'b1;
        base = edge_cnt;
        bus_write(5'd2, 32'h0000_0081);
        wait_ready(n);
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL dvsr0_busy: got %0d want 16", n);
        end
        n_checks++;
        if (edge_cnt - base !== 8 || mosi_cap !== 8'h81) begin
            n_fail++;
            $display("FAIL dvsr0_edges_mosi: got %0d/%h want 8/81", edge_cnt - base, mosi_cap);
        end
        n_checks++;
        if (bus.rd_data !== 32'h0000_0181) begin
            n_fail++;
            $display("FAIL dvsr0_rx: got %h want 00000181", bus.rd_data);
        end
    endtask

    task automatic test_reset_mid();
        bus_write(5'd3, 32'h0000_0003);
        miso_loop = 1'b1;
        bus_write(5'd2, 32'h0000_00FF);
        repeat (19) @(negedge clk);
        n_checks++;
        if (spi_mosi !== 1'b1 || spi_ss_n !== 4'h0 || bus.rd_data[8] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_pre: got mosi %b ss_n %b ready %b want 1 0000 0",
                     spi_mosi, spi_ss_n, bus.rd_data[8]);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (spi_sclk !== 1'b0 || spi_mosi !== 1'b0 || spi_ss_n !== 4'hF) begin
            n_fail++;
            $display("FAIL rstmid_async: got sclk %b mosi %b ss_n %b want 0 0 1111",
                     spi_sclk, spi_mosi, spi_ss_n);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.rd_data !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL rstmid_rd: got %h want 00000100", bus.rd_data);
        end
    endtask

    task automatic test_ss();
        int n;
        int base;
        bus_write(5'd1, 32'h0000_000E);
        n_checks++;
        if (spi_ss_n !== 4'b1110) begin
            n_fail++;
            $display("FAIL ss_idle: got %b want 1110", spi_ss_n);
        end
        bus_write(5'd1, 32'h0000_0000);
        bus_write(5'd3, 32'h0000_0003);
        miso_loop = 1'b1;
        base = edge_cnt;
        bus_write(5'd2, 32'h0000_0096);
        repeat (10) @(negedge clk);
        bus_write(5'd1, 32'h0000_000E);
        n_checks++;
        if (spi_ss_n !== 4'b1110 || bus.rd_data[8] !== 1'b0) begin
            n_fail++;
            $display("FAIL ss_mid: got ss_n %b ready %b want 1110 0", spi_ss_n, bus.rd_data[8]);
        end
        wait_ready(n);
        n_checks++;
        if (edge_cnt - base !== 8 || bus.rd_data !== 32'h0000_0196) begin
            n_fail++;
            $display("FAIL ss_xfer: got edges %0d rd %h want 8 00000196", edge_cnt - base, bus.rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_dvsr0();
        test_reset_mid();
        test_ss();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_mmio_core.md
Name: spi_mmio_core

Overview:
- Single-slot SPI master core on the MMIO slot bus of the vanilla I/O subsystem.
- Sits directly downstream of the MMIO subsystem's slot decoder and drives the accelerometer's SPI pins (sclk/mosi/miso/ss_n).
- Software sets the divisor and mode, asserts slave-select, writes a byte, polls ready, then reads back the received byte.
- Full-duplex, 8 bits per transfer, MSB first.

Parameters:
S, 1, number of slave-select lines (1..8)

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-high reset
cs  in  1  slot chip select
read  in  1  read strobe, qualified by cs
write  in  1  write strobe, qualified by cs
addr  in  5  slot register index; only addr[1:0] decoded
wr_data  in  32  write data
rd_data  out  32  read data
spi_sclk  out  1  SPI clock, registered
spi_mosi  out  1  SPI data out, registered
spi_miso  in  1  SPI data in
spi_ss_n  out  S  active-low slave selects

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. Reset values:
  - spi_ss_n all ones; spi_sclk 0; spi_mosi 0.
  - rx byte 0; ctrl 0 (dvsr=0, cpol=0, cpha=0).
  - FSM in IDLE; rd_data = 0x0000_0100 (ready=1).
- Register map (writes need cs&write at a clk edge):
  - addr 1: spi_ss_n <= wr_data[S-1:0]. Always accepted, including mid-transfer.
  - addr 2: start transfer with tx = wr_data[7:0]. Accepted only in IDLE; ignored while busy.
  - addr 3: ctrl <= {cpha=wr_data[17], cpol=wr_data[16], dvsr=wr_data[15:0]}. Accepted only in IDLE; ignored while busy.
  - addr 0: writes ignored.
- Reads: rd_data = {23'b0, ready, rx[7:0]} for every address. Combinational, no side effects; read strobe is not needed.
- ready = (state==IDLE).
- Half-period H = dvsr+1 clk cycles. A 16-bit counter counts 0..dvsr and resets on every state change.
- FSM:
  - IDLE: on accepted start, load the shift register, clear the bit count, and set mosi=tx[7]. Go to DLY if cpha=1, otherwise P0.
  - DLY: hold for H cycles, then go to P0.
  - P0: hold for H cycles. On the last cycle, sample spi_miso into the shift register LSB, then go to P1.
  - P1: hold for H cycles. On the last cycle:
    - if bit count==7: rx <= shift register (including the miso bit sampled in bit 7's P0), go to IDLE;
    - else: shift left, drive mosi with the next MSB, increment bit count, go to P0.
- spi_sclk is registered, based on the next state:
  - cpol^cpha in P0;
  - cpol^~cpha in P1;
  - cpol in IDLE/DLY.
  - Net effect: for either cpha, miso is sampled at the end of P0.
- Latency: for a start accepted at edge T, ready falls after T. Ready returns after T+16H cycles (cpha=0) or T+17H (cpha=1). rx is valid in the same cycle ready returns.
- Boundary conditions:
  - dvsr=0 (H=1) is legal and gives SCLK = clk/2.
  - dvsr=0xFFFF has no counter overflow.
  - A start write and a ctrl write cannot coincide (single bus).
  - A start write in the same cycle the FSM returns to IDLE is ignored, because state is still busy at that edge.
  - Reset mid-transfer: immediate return to IDLE with reset values. Partial rx is discarded (rx=0).
  - ss_n is never driven by the FSM; software owns it.

Test Plan:
1. Reset, then read any address -> rd_data=0x0000_0100; spi_ss_n=all ones; spi_sclk=0.
2. ctrl=0x0000_0003 (H=4, mode 0), ss_n=0, write 0xA5 with miso looped to mosi -> exactly 8 sclk rising edges; mosi bits 1,0,1,0,0,1,0,1; ready=0 for 64 cycles; then rd_data=0x0000_01A5.
3. ctrl=0x0003_0000 (cpol=1, cpha=1, H=1), write 0x3C with miso tied 1 -> sclk idles 1; first transition after 1 DLY cycle; busy for 17 cycles; rd_data=0x0000_01FF.
4. During the scenario 2 transfer, write 0x5A to addr 2 and 0x0001_0000 to addr 3 -> mosi sequence and sclk polarity unchanged, final rx=0xA5. A later ctrl readback via behaviour shows cpol still 0.
5. Assert reset at cycle 20 of a transfer -> same cycle: sclk=0, mosi=0, ss_n=all ones; after release, rd_data=0x0000_0100.
6. S=4: write addr 1 = 0xE -> spi_ss_n=4'b1110 next cycle, also when issued mid-transfer; the transfer completes unaffected.
